fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_ctrl.sv | 72 +++++++
 tb/tb_fetch_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller
package fetch_pkg;
    typedef enum logic {RUN, HALT} state_t;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] HALT_WORD = 32'h00000000;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-stage instruction fetch with valid/ready output, redirect and halt-on-zero-word
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rd,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic                     halted,
    output logic [31:0]              fetch_count
);
    state_t state, state_n;
    logic [ADDRESS_WIDTH-1:0] pc, pc_n, out_pc_n;
    logic [DATA_WIDTH-1:0] out_instr_n;
    logic out_valid_n, hs, cap;
    assign imem_addr = pc;
    assign halted = state == HALT;
    assign hs = out_valid & out_ready;
    assign cap = state == RUN && !redirect_valid && (!out_valid || out_ready);
    // redirect beats capture; a halt word is swallowed, never presented
    always_comb begin
        state_n = state;
        pc_n = pc;
        out_pc_n = out_pc;
        out_instr_n = out_instr;
        out_valid_n = out_valid;
        if (redirect_valid) begin
            pc_n = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            out_valid_n = 1'b0;
            state_n = RUN;
        end else if (cap) begin
            if (imem_rd == DATA_WIDTH'(HALT_WORD)) begin
                state_n = HALT;
                out_valid_n = 1'b0;
            end else begin
                out_instr_n = imem_rd;
                out_pc_n = pc;
                out_valid_n = 1'b1;
                pc_n = pc + ADDRESS_WIDTH'(INSTR_BYTES);
            end
        end else if (hs) begin
            out_valid_n = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc <= '0;
            fetch_count <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            out_valid <= out_valid_n;
            out_instr <= out_instr_n;
            out_pc <= out_pc_n;
            fetch_count <= fetch_count + 32'(hs);
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized redirect/backpressure against a behavioural model
module tb_fetch_ctrl;
    logic clk = 0, rst = 1;
    logic [31:0] imem_addr, imem_rd, redirect_pc, out_instr, out_pc, fetch_count;
    logic redirect_valid = 0, out_ready = 0, out_valid, halted;
    logic [31:0] mem [16];
    int ntests = 0, nfail = 0;
    logic [31:0] m_pc, m_instr, m_opc, m_cnt;
    logic m_valid, m_halt;

    always #5 clk = ~clk;
    assign imem_rd = mem[imem_addr[5:2]];

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .halted(halted), .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_valid = 0; m_halt = 0; m_instr = 0; m_opc = 0; m_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1; redirect_valid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_cnt", fetch_count, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_addr", imem_addr, 0);
        rst = 0;
    endtask

    // one clock: apply inputs, advance the model by the fetch rules, compare
    task automatic cyc(input logic rv, input logic [31:0] rp, input logic rdy);
        logic [31:0] w;
        redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
        #1;
        chk("addr_pre", imem_addr, m_pc);
        if (m_valid && rdy) m_cnt++;
        if (rv) begin
            m_pc = rp & ~32'd3; m_valid = 0; m_halt = 0;
        end else if (!m_halt && (!m_valid || rdy)) begin
            w = mem[m_pc[5:2]];
            if (w == 0) begin
                m_halt = 1; m_valid = 0;
            end else begin
                m_instr = w; m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
            end
        end else if (m_valid && rdy) m_valid = 0;
        @(posedge clk);
        #1;
        chk("valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_pc", out_pc, m_opc);
            chk("out_instr", out_instr, m_instr);
        end
        chk("halted", 32'(halted), 32'(m_halt));
        chk("count", fetch_count, m_cnt);
        chk("addr", imem_addr, m_pc);
    endtask

    initial begin
        mem = '{32'h0FF00313, 32'h00000513, 32'h00000593, 32'h00058513,
                32'h00100093, 32'h00208113, 32'h00310193, 32'h00000000,
                32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        do_reset();
        cyc(0, 0, 1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_instr", out_instr, 32'h0FF00313);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("third_pc", out_pc, 32'h8);
        cyc(0, 0, 1);
        chk("cnt3", fetch_count, 3);
        do_reset();
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        repeat (3) cyc(0, 0, 0);
        chk("hold_instr", out_instr, 32'h00000513);
        chk("hold_addr", imem_addr, 32'h8);
        chk("hold_cnt", fetch_count, 1);
        repeat (6) cyc(0, 0, 1);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_addr", imem_addr, 32'h1c);
        repeat (2) cyc(0, 0, 1);
        cyc(1, 32'h0000000E, 1);
        chk("exit_halt", 32'(halted), 0);
        chk("redir_pc", imem_addr, 32'h0C);
        cyc(0, 0, 1);
        chk("redir_out_pc", out_pc, 32'h0C);
        chk("redir_instr", out_instr, 32'h00058513);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("pre_hs_pc", out_pc, 32'h14);
        cyc(1, 32'h10, 1);
        chk("redir_flush", 32'(out_valid), 0);
        cyc(0, 0, 1);
        chk("after_redir_pc", out_pc, 32'h10);
        // asynchronous reset mid-operation, away from any clock edge
        #2;
        rst = 1;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_cnt", fetch_count, 0);
        chk("async_addr", imem_addr, 0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        cyc(0, 0, 1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++)
                mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
            mem[0] = 32'h00000013;
            do_reset();
            for (int k = 0; k < 300; k++)
                cyc($urandom_range(0, 7) == 0, $urandom_range(0, 63), $urandom_range(0, 3) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
